// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch_entry_t with flush; the head entry is read combinationally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  fetch_entry_t               i_push_data,
  input  logic                       i_pop,
  output fetch_entry_t               o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  // Flush wins over both push and pop; a push into a full FIFO is legal only alongside a pop.
  assign w_do_pop  = i_pop & ~w_empty & ~i_flush;
  assign w_do_push = i_push & ~i_flush & (~w_full | w_do_pop);

  // NOTE: the storage array is deliberately not reset; pointers and count alone say which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_flush && w_full && !i_pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_pop && !i_flush && w_empty));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, in-order imem requests, prefetch buffer toward decode, redirect flush with
// discard of responses still in flight for the old stream.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        id_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_drop_cnt;

  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp_fire;
  logic            w_rsp_keep;
  logic            w_pop;
  logic            w_inst_valid;
  logic            w_has_room;
  logic [CW:0]     w_occupancy;
  logic [CW-1:0]   w_outstanding;
  logic [CW-1:0]   w_buf_count;
  fetch_entry_t    w_pend_in;
  fetch_entry_t    w_pend_head;
  fetch_entry_t    w_buf_in;
  fetch_entry_t    w_buf_head;
  logic            w_unused;

  // The pending-PC queue holds exactly the accepted-but-unreturned requests, so its count is `outstanding`.
  assign w_occupancy  = {1'b0, w_outstanding} + {1'b0, w_buf_count};
  assign w_has_room   = (w_occupancy < (CW + 1)'(DEPTH));
  assign w_req_valid  = rst_n & ~redirect_valid & w_has_room;
  assign w_req_fire   = w_req_valid & imem_req_ready;
  assign w_rsp_fire   = imem_rsp_valid;
  assign w_rsp_keep   = w_rsp_fire & (r_drop_cnt == '0) & ~redirect_valid;
  assign w_inst_valid = (w_buf_count != '0);
  assign w_pop        = w_inst_valid & id_ready;

  assign w_pend_in = '{inst: '0, pc: r_pc};
  assign w_buf_in  = '{inst: imem_rsp_data, pc: w_pend_head.pc};

  fetch_fifo #(.DEPTH(DEPTH)) u_pend_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (1'b0),
    .i_push      (w_req_fire),
    .i_push_data (w_pend_in),
    .i_pop       (w_rsp_fire),
    .o_head      (w_pend_head),
    .o_count     (w_outstanding)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_prefetch_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (redirect_valid),
    .i_push      (w_rsp_keep),
    .i_push_data (w_buf_in),
    .i_pop       (w_pop),
    .o_head      (w_buf_head),
    .o_count     (w_buf_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[31:2], 2'b00};
    end else if (w_req_fire) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // On redirect every request still in flight after this edge belongs to the old stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      r_drop_cnt <= w_outstanding - CW'(w_rsp_fire);
    end else if (w_rsp_fire && (r_drop_cnt != '0)) begin
      r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = w_inst_valid;
  assign inst_out       = w_inst_valid ? w_buf_head.inst : NOP_INST;
  assign inst_pc        = w_inst_valid ? w_buf_head.pc : '0;

  assign w_unused = ^{w_pend_head.inst, redirect_pc[1:0]};

endmodule
